mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Load/store front-end that sits directly upstream of the word-wide Ram and drives its read and write ports.
- Accepts byte-addressed byte, halfword and word requests from the pipeline's MEM stage.
- Loads: extracts the addressed lane and sign- or zero-extends it. Sub-word stores: read-modify-write, since the Ram has no byte enables.
- Misaligned and illegal-size requests are flagged and make no Ram access.

Parameters:
- ADDR_WIDTH, 32, width of the byte address from the pipeline.
- RAM_ADDR_WIDTH, 10, Ram word-address width; word index = addr[RAM_ADDR_WIDTH+1:2].
- TAG, "MAU", prefix for debug display messages.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- res  in  1  reset, synchronous, active-high.
- req  in  1  request valid; sampled only while ready=1.
- wr  in  1  1 = store, 0 = load.
- size  in  2  00 = byte, 01 = halfword, 10 = word, 11 = illegal.
- signExt  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- addr  in  ADDR_WIDTH  byte address.
- wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- ready  out  1  block is idle and can accept a request.
- done  out  1  one-cycle completion pulse.
- misaligned  out  1  valid with done; 1 = request rejected.
- rdata  out  32  load result (extended).
- ramRe  out  1  Ram read enable.
- ramWe  out  1  Ram write enable.
- ramReadAddr  out  RAM_ADDR_WIDTH  Ram read word address.
- ramWriteAddr  out  RAM_ADDR_WIDTH  Ram write word address.
- ramDataIn  out  32  data to Ram write port.
- ramDataOut  in  32  Ram read data; valid the cycle after a ramRe edge.

Behaviour:
- Reset (res=1 at an edge): state=IDLE, ready=1, done=0, misaligned=0, rdata=0, ramRe=0, ramWe=0, latched request and merge buffer = 0.
- FSM states: IDLE, READ, CAPTURE, WRITE, DONE, ERR. ramRe/ramWe/done/misaligned are Moore outputs decoded from state.
- IDLE: ready=1. On req=1, latch addr, wr, size, signExt and wdata, then branch:
  - misaligned or illegal (size=11; half with addr[0]=1; word with addr[1:0]!=0) -> ERR.
  - word store -> WRITE, merge buffer = wdata.
  - otherwise -> READ.
  - req=0 stays in IDLE.
- READ: ramRe=1, ramReadAddr = latched word index. Next state is CAPTURE.
- CAPTURE: ramDataOut is valid.
  - Load: rdata <= extracted lane, extended per signExt -> DONE.
  - Sub-word store: merge buffer <= ramDataOut with the addressed lane replaced by wdata -> WRITE.
- WRITE: ramWe=1, ramWriteAddr = word index, ramDataIn = merge buffer. Next state is DONE.
- DONE: done=1, misaligned=0. Next state is IDLE. ERR: done=1, misaligned=1, no Ram enable asserted. Next state is IDLE.
- Lane map is little-endian:
  - byte lane = addr[1:0], bits [8*lane+7 : 8*lane].
  - half lane = addr[1], bits [16*addr[1]+15 : 16*addr[1]].
- Latency (edge of acceptance to the done cycle, inclusive):
  - load: 3 cycles.
  - word store: 2 cycles.
  - sub-word store: 4 cycles.
  - error: 1 cycle.
- ramRe and ramWe are never high in the same cycle. Ram write has priority, so simultaneous assertion would corrupt the read latch.
- req while ready=0 is ignored, not queued. Input changes after acceptance have no effect.
- rdata holds its value across stores and errors. It changes only in CAPTURE of a load.
- Back-to-back: req may be asserted in the cycle after DONE, since IDLE accepts immediately.
- Address bits above RAM_ADDR_WIDTH+1 are ignored (wrap-around within the Ram).
- Reset mid-operation aborts in the next cycle. A sub-word store reset before WRITE leaves the Ram unmodified. No done pulse is issued for an aborted request.
- Under DEBUG_DISPLAY: print TAG, operation, address and data on each DONE/ERR.

Test Plan:
- Word store then word load: store 0xDEADBEEF @0x10, then load @0x10 -> ramWe pulses at word 4; second done 3 cycles after acceptance; rdata=0xDEADBEEF.
- Byte store RMW: word 0x11223344 @0x20, store byte 0xAA @0x22 -> ramRe, then ramWe 2 cycles later with ramDataIn=0x11AA3344; done 4 cycles after acceptance.
- Sign/zero extension: word 0x80F0_7F01 @0x30.
  - lb @0x32 signExt=1 -> rdata=0xFFFFFFF0.
  - lbu @0x33 -> 0x00000080.
  - lh @0x32 signExt=1 -> 0xFFFF80F0.
- Misaligned: lw @0x41 and lh @0x43 -> done with misaligned=1 one cycle after acceptance; ramRe=ramWe=0 throughout; rdata unchanged.
- Reset mid-RMW: word 0x55555555 @0x50, sb 0x00 @0x50, assert res in CAPTURE -> no ramWe; subsequent lw @0x50 returns 0x55555555.
- Ignored req: hold req=1 continuously for 3 consecutive loads -> exactly 3 done pulses with ready low between; no ramRe/ramWe overlap in any cycle.

Source files
------------

// File: rtl/mem_access_unit.sv
// ============================================================================
// mem_access_unit
//   Byte/halfword/word load-store front-end for a word-wide Ram without byte
//   enables; sub-word stores are done as read-modify-write.
//   Revision: 1.0
// ============================================================================
`default_nettype none

module mem_access_unit #(
    parameter int ADDR_WIDTH     = 32,
    parameter int RAM_ADDR_WIDTH = 10,
    parameter     TAG            = "MAU"
) (
    input  logic                      clk,
    input  logic                      res,
    input  logic                      req,
    input  logic                      wr,
    input  logic [1:0]                size,
    input  logic                      signExt,
    input  logic [ADDR_WIDTH-1:0]     addr,
    input  logic [31:0]               wdata,
    output logic                      ready,
    output logic                      done,
    output logic                      misaligned,
    output logic [31:0]               rdata,
    output logic                      ramRe,
    output logic                      ramWe,
    output logic [RAM_ADDR_WIDTH-1:0] ramReadAddr,
    output logic [RAM_ADDR_WIDTH-1:0] ramWriteAddr,
    output logic [31:0]               ramDataIn,
    input  logic [31:0]               ramDataOut
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_READ    = 3'd1,
        S_CAPTURE = 3'd2,
        S_WRITE   = 3'd3,
        S_DONE    = 3'd4,
        S_ERR     = 3'd5
    } state_t;

    state_t                    r_state;
    logic [RAM_ADDR_WIDTH-1:0] r_word_idx;
    logic [1:0]                r_lane;
    logic                      r_wr;
    logic [1:0]                r_size;
    logic                      r_sext;
    logic [31:0]               r_wdata;
    logic [31:0]               r_merge;
    logic [31:0]               r_rdata;

    logic                      w_bad;
    logic [7:0]                w_byte;
    logic [15:0]               w_half;
    logic [31:0]               w_load;
    logic [31:0]               w_merge;
    logic                      w_unused;

    // Address bits above the Ram word index wrap around and are not used.
    assign w_unused = ^{TAG, addr[ADDR_WIDTH-1:RAM_ADDR_WIDTH+2]};

    assign w_bad = (size == 2'b11)
                || ((size == 2'b01) && addr[0])
                || ((size == 2'b10) && (addr[1:0] != 2'b00));

    always_comb begin
        w_byte = ramDataOut[{r_lane, 3'b000} +: 8];
        w_half = ramDataOut[{r_lane[1], 4'b0000} +: 16];
        case (r_size)
            2'b00:   w_load = {{24{r_sext & w_byte[7]}}, w_byte};
            2'b01:   w_load = {{16{r_sext & w_half[15]}}, w_half};
            default: w_load = ramDataOut;
        endcase
        w_merge = ramDataOut;
        if (r_size == 2'b00) begin
            w_merge[{r_lane, 3'b000} +: 8] = r_wdata[7:0];
        end else begin
            w_merge[{r_lane[1], 4'b0000} +: 16] = r_wdata[15:0];
        end
    end

    always_ff @(posedge clk) begin
        if (res) begin
            r_state    <= S_IDLE;
            r_word_idx <= '0;
            r_lane     <= 2'b00;
            r_wr       <= 1'b0;
            r_size     <= 2'b00;
            r_sext     <= 1'b0;
            r_wdata    <= '0;
            r_merge    <= '0;
            r_rdata    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req) begin
                        r_word_idx <= addr[RAM_ADDR_WIDTH+1:2];
                        r_lane     <= addr[1:0];
                        r_wr       <= wr;
                        r_size     <= size;
                        r_sext     <= signExt;
                        r_wdata    <= wdata;
                        if (w_bad) begin
                            r_state <= S_ERR;
                        end else if (wr && (size == 2'b10)) begin
                            r_merge <= wdata;
                            r_state <= S_WRITE;
                        end else begin
                            r_state <= S_READ;
                        end
                    end
                end
                S_READ: r_state <= S_CAPTURE;
                S_CAPTURE: begin
                    if (r_wr) begin
                        r_merge <= w_merge;
                        r_state <= S_WRITE;
                    end else begin
                        r_rdata <= w_load;
                        r_state <= S_DONE;
                    end
                end
                S_WRITE: r_state <= S_DONE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign ready        = (r_state == S_IDLE);
    assign done         = (r_state == S_DONE) || (r_state == S_ERR);
    assign misaligned   = (r_state == S_ERR);
    assign ramRe        = (r_state == S_READ);
    assign ramWe        = (r_state == S_WRITE);
    assign ramReadAddr  = r_word_idx;
    assign ramWriteAddr = r_word_idx;
    assign ramDataIn    = r_merge;
    assign rdata        = r_rdata;

`ifdef DEBUG_DISPLAY
    always_ff @(posedge clk) begin
        if (!res && done) begin
            $display("%s: %s size=%0d word=%h lane=%0d wdata=%h rdata=%h err=%0b",
                     TAG, r_wr ? "ST" : "LD", r_size, r_word_idx, r_lane,
                     r_wdata, r_rdata, misaligned);
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: scoreboard of expected completions,
// behavioural Ram, and a reference memory image.
`default_nettype none
`timescale 1ns/1ps

module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        res = 1'b1;
    logic        req = 1'b0;
    logic        wr = 1'b0;
    logic [1:0]  size = 2'b00;
    logic        signExt = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        ready, done, misaligned, ramRe, ramWe;
    logic [31:0] rdata, ramDataIn;
    logic [31:0] ramDataOut = '0;
    logic [9:0]  ramReadAddr, ramWriteAddr;

    always #5 clk = ~clk;

    mem_access_unit #(.ADDR_WIDTH(32), .RAM_ADDR_WIDTH(10), .TAG("MAU")) dut (
        .clk(clk), .res(res), .req(req), .wr(wr), .size(size),
        .signExt(signExt), .addr(addr), .wdata(wdata), .ready(ready),
        .done(done), .misaligned(misaligned), .rdata(rdata),
        .ramRe(ramRe), .ramWe(ramWe), .ramReadAddr(ramReadAddr),
        .ramWriteAddr(ramWriteAddr), .ramDataIn(ramDataIn),
        .ramDataOut(ramDataOut)
    );

    // Behavioural Ram: registered read, write port independent.
    logic [31:0] bram [0:1023];
    always @(posedge clk) begin
        if (ramWe) bram[ramWriteAddr] <= ramDataIn;
        if (ramRe) ramDataOut <= bram[ramReadAddr];
    end

    typedef struct {
        string       tag;
        logic        mis;
        logic [31:0] rd;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    int          acc_q[$];
    logic [31:0] refm [0:1023];
    logic [31:0] hold = '0;
    int          cyc = 0;
    int          passed = 0, total = 0, failed = 0;
    int          re_cnt = 0, we_cnt = 0, overlap = 0, acc_total = 0;
    int          last_re_cyc = 0, last_we_cyc = 0;
    logic [9:0]  last_wa = '0;
    logic [31:0] last_wd = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Monitor: records Ram activity, acceptances, and scores every completion.
    always @(negedge clk) begin
        if (ramRe && ramWe) overlap++;
        if (ramRe) begin re_cnt++; last_re_cyc = cyc; end
        if (ramWe) begin
            we_cnt++; last_we_cyc = cyc; last_wa = ramWriteAddr; last_wd = ramDataIn;
        end
        if (res) begin
            acc_q.delete();
        end else begin
            if (ready && req) begin acc_q.push_back(cyc); acc_total++; end
            if (done) begin
                exp_t e;
                int   a;
                chk("sb_pending", 32'(sb.size() > 0), 32'd1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    a = (acc_q.size() > 0) ? acc_q.pop_front() : -100;
                    chk({e.tag, ".mis"}, 32'(misaligned), 32'(e.mis));
                    chk({e.tag, ".rdata"}, rdata, e.rd);
                    chk({e.tag, ".lat"}, 32'(cyc - a), 32'(e.lat));
                end
            end
        end
    end

    // Reference model: compute the expected completion and update the image.
    task automatic push_exp(input logic w, input logic [1:0] sz, input logic sx,
                            input logic [31:0] a, input logic [31:0] d, input string tag);
        exp_t        e;
        logic [9:0]  idx;
        logic [1:0]  ln;
        logic [31:0] word;
        logic [7:0]  b;
        logic [15:0] h;
        idx   = a[11:2];
        ln    = a[1:0];
        word  = refm[idx];
        e.tag = tag;
        e.mis = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && ln != 2'd0);
        if (e.mis) begin
            e.lat = 1;
        end else if (w) begin
            if (sz == 2'd0) word[8*ln +: 8] = d[7:0];
            else if (sz == 2'd1) word[16*ln[1] +: 16] = d[15:0];
            else word = d;
            refm[idx] = word;
            e.lat = (sz == 2'd2) ? 2 : 4;
        end else begin
            b = word[8*ln +: 8];
            h = word[16*ln[1] +: 16];
            if (sz == 2'd0) hold = sx ? {{24{b[7]}}, b} : {24'd0, b};
            else if (sz == 2'd1) hold = sx ? {{16{h[15]}}, h} : {16'd0, h};
            else hold = word;
            e.lat = 3;
        end
        e.rd = hold;
        sb.push_back(e);
    endtask

    task automatic drive(input logic w, input logic [1:0] sz, input logic sx,
                         input logic [31:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        wr = w; size = sz; signExt = sx; addr = a; wdata = d; req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        wr = ~w; size = 2'($urandom); signExt = ~sx; addr = $urandom; wdata = $urandom;
    endtask

    task automatic do_op(input logic w, input logic [1:0] sz, input logic sx,
                         input logic [31:0] a, input logic [31:0] d, input string tag);
        int seen;
        push_exp(w, sz, sx, a, d, tag);
        drive(w, sz, sx, a, d);
        seen = 0;
        for (int i = 0; i < 20 && seen == 0; i++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        chk({tag, ".timeout"}, 32'(seen), 32'd1);
    endtask

    initial begin
        int re0, we0, acc0, seen;
        for (int i = 0; i < 1024; i++) begin bram[i] = '0; refm[i] = '0; end

        // Reset state
        repeat (3) @(posedge clk);
        #1 res = 1'b0;
        @(negedge clk);
        chk("rst.ready", 32'(ready), 32'd1);
        chk("rst.done", 32'(done), 32'd0);
        chk("rst.mis", 32'(misaligned), 32'd0);
        chk("rst.rdata", rdata, 32'd0);
        chk("rst.ram_en", {30'd0, ramRe, ramWe}, 32'd0);

        // Word store then word load
        do_op(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, "sw10");
        chk("sw10.waddr", 32'(last_wa), 32'd4);
        chk("sw10.wdata", last_wd, 32'hDEADBEEF);
        do_op(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, "lw10");
        chk("lw10.value", rdata, 32'hDEADBEEF);

        // Byte store read-modify-write
        do_op(1'b1, 2'd2, 1'b0, 32'h20, 32'h11223344, "sw20");
        do_op(1'b1, 2'd0, 1'b0, 32'h22, 32'h000000AA, "sb22");
        chk("sb22.wdata", last_wd, 32'h11AA3344);
        chk("sb22.waddr", 32'(last_wa), 32'd8);
        chk("sb22.re_to_we", 32'(last_we_cyc - last_re_cyc), 32'd2);

        // Sign / zero extension
        do_op(1'b1, 2'd2, 1'b0, 32'h30, 32'h80F07F01, "sw30");
        do_op(1'b0, 2'd0, 1'b1, 32'h32, 32'h0, "lb32");
        chk("lb32.value", rdata, 32'hFFFFFFF0);
        do_op(1'b0, 2'd0, 1'b0, 32'h33, 32'h0, "lbu33");
        chk("lbu33.value", rdata, 32'h00000080);
        do_op(1'b0, 2'd1, 1'b1, 32'h32, 32'h0, "lh32");
        chk("lh32.value", rdata, 32'hFFFF80F0);
        do_op(1'b0, 2'd1, 1'b0, 32'h30, 32'h0, "lhu30");
        do_op(1'b1, 2'd1, 1'b0, 32'h32, 32'h0000BEEF, "sh32");
        do_op(1'b0, 2'd2, 1'b0, 32'h30, 32'h0, "lw30");
        chk("lw30.value", rdata, 32'hBEEF7F01);

        // Misaligned and illegal requests make no Ram access
        re0 = re_cnt; we0 = we_cnt;
        do_op(1'b0, 2'd2, 1'b0, 32'h41, 32'h0, "lw41");
        do_op(1'b0, 2'd1, 1'b1, 32'h43, 32'h0, "lh43");
        do_op(1'b1, 2'd3, 1'b0, 32'h44, 32'h12345678, "ill44");
        chk("mis.re_cnt", 32'(re_cnt - re0), 32'd0);
        chk("mis.we_cnt", 32'(we_cnt - we0), 32'd0);
        chk("mis.rdata_held", rdata, 32'hBEEF7F01);

        // Upper address bits wrap within the Ram
        do_op(1'b0, 2'd2, 1'b0, 32'h1000_0010, 32'h0, "lw_wrap");
        chk("lw_wrap.value", rdata, 32'hDEADBEEF);

        // Reset during the capture phase of a byte store aborts it
        do_op(1'b1, 2'd2, 1'b0, 32'h50, 32'h55555555, "sw50");
        we0 = we_cnt;
        drive(1'b1, 2'd0, 1'b0, 32'h50, 32'h00000000);
        @(posedge clk); #1 res = 1'b1;
        @(posedge clk); #1 res = 1'b0;
        hold = '0;
        repeat (4) @(negedge clk);
        chk("abort.we_cnt", 32'(we_cnt - we0), 32'd0);
        chk("abort.ready", 32'(ready), 32'd1);
        chk("abort.rdata", rdata, 32'd0);
        do_op(1'b0, 2'd2, 1'b0, 32'h50, 32'h0, "lw50");
        chk("lw50.value", rdata, 32'h55555555);

        // req held high: one acceptance per completion, nothing queued
        acc0 = acc_total;
        for (int k = 0; k < 3; k++) push_exp(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, "held");
        @(posedge clk); #1;
        wr = 1'b0; size = 2'd2; signExt = 1'b0; addr = 32'h20; req = 1'b1;
        seen = 0;
        for (int i = 0; i < 60 && seen < 3; i++) begin
            @(negedge clk);
            if (done) seen++;
        end
        @(posedge clk); #1 req = 1'b0;
        repeat (6) @(negedge clk);
        chk("held.dones", 32'(seen), 32'd3);
        chk("held.accepts", 32'(acc_total - acc0), 32'd3);
        chk("held.value", rdata, 32'h11AA3344);
        chk("sb.drained", 32'(sb.size()), 32'd0);
        chk("no_re_we_overlap", 32'(overlap), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
